// File: rtl/vc_plane_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vc_plane_scheduler_pkg
// Description : Flit-type codes and scheduler FSM state encodings shared by
//               the VC plane scheduler and the router control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package vc_plane_scheduler_pkg;

    // Flit type codes carried in the top two bits of every flit
    localparam logic [1:0] c_FLIT_HEADTAIL = 2'b00;
    localparam logic [1:0] c_FLIT_HEAD     = 2'b01;
    localparam logic [1:0] c_FLIT_BODY     = 2'b10;
    localparam logic [1:0] c_FLIT_TAIL     = 2'b11;

    // Read-side scheduler states: waiting for a request, or holding a plane
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } sched_state_t;

    // True for the flit that closes a packet (tail or single-flit packet)
    function automatic logic is_last_flit(input logic [1:0] flit_type);
        return (flit_type == c_FLIT_TAIL) || (flit_type == c_FLIT_HEADTAIL);
    endfunction

endpackage : vc_plane_scheduler_pkg
`default_nettype wire

// File: rtl/vc_plane_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vc_plane_scheduler_rr_arbiter
// Description : Combinational round-robin arbiter. Searches the request
//               vector starting one above the previous winner, wrapping
//               modulo VC, and returns the winner as one-hot and as index.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_plane_scheduler_rr_arbiter #(
    parameter int VC    = 4,
    parameter int IDX_W = 2
) (
    input  logic [VC-1:0]    i_req,
    input  logic [IDX_W-1:0] i_last_grant,
    output logic [VC-1:0]    o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_grant_valid
);

    // Plane index reached by stepping 'off' positions above 'base', modulo VC
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int               off);
        int sum;
        sum = int'(base) + off;
        if (sum >= VC) begin
            sum = sum - VC;
        end
        return IDX_W'(sum);
    endfunction

    // First requester after the last winner; the last winner itself is checked last
    always_comb begin
        o_grant       = '0;
        o_grant_idx   = '0;
        o_grant_valid = 1'b0;
        for (int off = 1; off <= VC; off++) begin
            if (!o_grant_valid && i_req[wrap_idx(i_last_grant, off)]) begin
                o_grant_valid                         = 1'b1;
                o_grant_idx                           = wrap_idx(i_last_grant, off);
                o_grant[wrap_idx(i_last_grant, off)]  = 1'b1;
            end
        end
    end

endmodule : vc_plane_scheduler_rr_arbiter
`default_nettype wire

// File: rtl/vc_plane_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : vc_plane_scheduler
// Description : Read-side scheduler for a virtual-channel buffer group.
//               Grants one non-empty plane round-robin, holds it from head
//               to tail flit, drives the plane select and FIFO pop, and
//               force-releases a plane that stays empty for STALL_MAX cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module vc_plane_scheduler
    import vc_plane_scheduler_pkg::*;
#(
    parameter int VC         = 4,
    parameter int DATA_WIDTH = 32,
    parameter int STALL_MAX  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [VC-1:0]          vc_empty,
    input  logic [1:0]             flit_type,
    input  logic                   out_ready,
    output logic [VC:0]            vc_plane_sel,
    output logic                   pop,
    output logic                   out_valid,
    output logic [$clog2(VC)-1:0]  cur_vc,
    output logic                   pkt_done,
    output logic                   stall_release
);

    localparam int IDX_W = $clog2(VC);
    localparam int CNT_W = $clog2(STALL_MAX) + 1;

    // Count value at which an empty locked plane is released
    localparam logic [CNT_W-1:0] c_STALL_LAST = CNT_W'(STALL_MAX - 1);
    // Select pattern meaning "no plane connected"
    localparam logic [VC:0]      c_SEL_NONE   = {1'b1, {VC{1'b0}}};
    // Reset value of the round-robin pointer so plane 0 wins first
    localparam logic [IDX_W-1:0] c_LAST_INIT  = IDX_W'(VC - 1);

    // Parameter sanity guards evaluated at elaboration
    if (VC < 2) begin : g_check_vc
        $error("vc_plane_scheduler: VC must be at least 2");
    end
    if (STALL_MAX < 1) begin : g_check_stall
        $error("vc_plane_scheduler: STALL_MAX must be at least 1");
    end
    if (DATA_WIDTH < 2) begin : g_check_width
        $error("vc_plane_scheduler: DATA_WIDTH must hold the 2-bit flit type");
    end

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    sched_state_t       r_state;
    logic [VC:0]        r_sel;
    logic [IDX_W-1:0]   r_cur_vc;
    logic [IDX_W-1:0]   r_last_grant;
    logic [CNT_W-1:0]   r_stall_cnt;
    logic               r_pkt_done;
    logic               r_stall_release;

    // ------------------------------------------------------------------------
    // Next-state and combinational outputs
    // ------------------------------------------------------------------------
    sched_state_t       w_state_nxt;
    logic [VC:0]        w_sel_nxt;
    logic [IDX_W-1:0]   w_cur_vc_nxt;
    logic [IDX_W-1:0]   w_last_grant_nxt;
    logic [CNT_W-1:0]   w_stall_cnt_nxt;
    logic               w_pkt_done_nxt;
    logic               w_stall_release_nxt;
    logic               w_out_valid;
    logic               w_pop;
    logic               w_cur_empty;

    // Arbiter interface
    logic [VC-1:0]      w_req;
    logic [VC-1:0]      w_arb_grant;
    logic [IDX_W-1:0]   w_arb_idx;
    logic               w_arb_valid;

    assign w_req       = ~vc_empty;
    assign w_cur_empty = vc_empty[r_cur_vc];

    vc_plane_scheduler_rr_arbiter #(
        .VC    (VC),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .i_req         (w_req),
        .i_last_grant  (r_last_grant),
        .o_grant       (w_arb_grant),
        .o_grant_idx   (w_arb_idx),
        .o_grant_valid (w_arb_valid)
    );

    // FSM next state, register updates and the combinational pop/valid outputs
    always_comb begin
        w_state_nxt         = r_state;
        w_sel_nxt           = r_sel;
        w_cur_vc_nxt        = r_cur_vc;
        w_last_grant_nxt    = r_last_grant;
        w_stall_cnt_nxt     = r_stall_cnt;
        w_pkt_done_nxt      = 1'b0;
        w_stall_release_nxt = 1'b0;
        w_out_valid         = 1'b0;
        w_pop               = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Grant is registered so the plane appears on the select next cycle
                if (w_arb_valid) begin
                    w_state_nxt     = ST_LOCKED;
                    w_cur_vc_nxt    = w_arb_idx;
                    w_sel_nxt       = {1'b0, w_arb_grant};
                    w_stall_cnt_nxt = '0;
                end
            end

            ST_LOCKED: begin
                w_out_valid = ~w_cur_empty;
                w_pop       = w_out_valid & out_ready;
                if (w_pop) begin
                    if (is_last_flit(flit_type)) begin
                        w_state_nxt      = ST_IDLE;
                        w_sel_nxt        = c_SEL_NONE;
                        w_cur_vc_nxt     = '0;
                        w_last_grant_nxt = r_cur_vc;
                        w_pkt_done_nxt   = 1'b1;
                    end else begin
                        w_stall_cnt_nxt  = '0;
                    end
                end else if (w_cur_empty) begin
                    // Only an empty locked plane ages the lock; back-pressure never does
                    if (r_stall_cnt == c_STALL_LAST) begin
                        w_state_nxt         = ST_IDLE;
                        w_sel_nxt           = c_SEL_NONE;
                        w_cur_vc_nxt        = '0;
                        w_last_grant_nxt    = r_cur_vc;
                        w_pkt_done_nxt      = 1'b1;
                        w_stall_release_nxt = 1'b1;
                    end else begin
                        w_stall_cnt_nxt     = r_stall_cnt + CNT_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt  = ST_IDLE;
                w_sel_nxt    = c_SEL_NONE;
                w_cur_vc_nxt = '0;
            end
        endcase
    end

    // State register; reset drops any lock at once and re-arms plane 0 as first winner
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_sel           <= c_SEL_NONE;
            r_cur_vc        <= '0;
            r_last_grant    <= c_LAST_INIT;
            r_stall_cnt     <= '0;
            r_pkt_done      <= 1'b0;
            r_stall_release <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_sel           <= w_sel_nxt;
            r_cur_vc        <= w_cur_vc_nxt;
            r_last_grant    <= w_last_grant_nxt;
            r_stall_cnt     <= w_stall_cnt_nxt;
            r_pkt_done      <= w_pkt_done_nxt;
            r_stall_release <= w_stall_release_nxt;
        end
    end

    assign vc_plane_sel  = r_sel;
    assign cur_vc        = r_cur_vc;
    assign pkt_done      = r_pkt_done;
    assign stall_release = r_stall_release;
    assign out_valid     = w_out_valid;
    assign pop           = w_pop;

endmodule : vc_plane_scheduler
`default_nettype wire

// File: tb/tb_vc_plane_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_vc_plane_scheduler
// Description : Self-checking bench for vc_plane_scheduler. Per-plane FIFOs
//               are modelled as circular arrays; a packet-level reference
//               (lock owner, consecutive-empty count, round-robin pointer)
//               predicts every output each cycle. Directed scenarios first,
//               then randomized traffic and back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vc_plane_scheduler;
    import vc_plane_scheduler_pkg::*;

    localparam int VC        = 4;
    localparam int STALL_MAX = 16;
    localparam int DEPTH     = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [VC-1:0]  vc_empty;
    logic [1:0]     flit_type;
    logic           out_ready;
    logic [VC:0]    vc_plane_sel;
    logic           pop;
    logic           out_valid;
    logic [1:0]     cur_vc;
    logic           pkt_done;
    logic           stall_release;

    vc_plane_scheduler #(
        .VC         (VC),
        .DATA_WIDTH (32),
        .STALL_MAX  (STALL_MAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .vc_empty      (vc_empty),
        .flit_type     (flit_type),
        .out_ready     (out_ready),
        .vc_plane_sel  (vc_plane_sel),
        .pop           (pop),
        .out_valid     (out_valid),
        .cur_vc        (cur_vc),
        .pkt_done      (pkt_done),
        .stall_release (stall_release)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-plane FIFO contents (also the stimulus source)
    logic [1:0] mem [VC][DEPTH];
    int         hd  [VC];
    int         cnt [VC];
    int         gen_rem [VC];

    // Reference model of the scheduler at packet level
    bit m_locked;
    int m_vc;
    int m_last;
    int m_run;
    bit m_done;
    bit m_srel;

    // Observation statistics for directed scenarios
    int n_pop;
    int n_done;
    int n_srel;
    int g_log [32];
    int g_n;
    bit prev_none;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_push(input int v, input logic [1:0] t);
        if (cnt[v] < DEPTH - 4) begin
            mem[v][(hd[v] + cnt[v]) % DEPTH] = t;
            cnt[v]++;
        end
    endtask

    task automatic fifo_clear();
        for (int v = 0; v < VC; v++) begin
            hd[v] = 0; cnt[v] = 0; gen_rem[v] = 0;
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0; m_vc = 0; m_last = VC - 1; m_run = 0;
        m_done = 1'b0; m_srel = 1'b0;
    endtask

    task automatic clr_stats();
        n_pop = 0; n_done = 0; n_srel = 0; g_n = 0; prev_none = 1'b1;
    endtask

    task automatic drive_inputs();
        for (int v = 0; v < VC; v++) vc_empty[v] = (cnt[v] == 0);
        if (m_locked && cnt[m_vc] > 0) flit_type = mem[m_vc][hd[m_vc]];
        else flit_type = 2'($urandom);
    endtask

    // Advance the reference by one clock given this cycle's inputs
    task automatic model_step(input logic rdy);
        logic [1:0] t;
        m_done = 1'b0;
        m_srel = 1'b0;
        if (!m_locked) begin
            for (int off = 1; off <= VC; off++) begin
                int k;
                k = (m_last + off) % VC;
                if (!m_locked && cnt[k] > 0) begin
                    m_locked = 1'b1; m_vc = k; m_run = 0;
                end
            end
        end else if (cnt[m_vc] > 0 && rdy) begin
            t = mem[m_vc][hd[m_vc]];
            hd[m_vc] = (hd[m_vc] + 1) % DEPTH;
            cnt[m_vc]--;
            if (t == c_FLIT_TAIL || t == c_FLIT_HEADTAIL) begin
                m_locked = 1'b0; m_last = m_vc; m_done = 1'b1;
            end else begin
                m_run = 0;
            end
        end else if (cnt[m_vc] == 0) begin
            m_run++;
            if (m_run == STALL_MAX) begin
                m_locked = 1'b0; m_last = m_vc; m_done = 1'b1; m_srel = 1'b1;
            end
        end
    endtask

    // One clock: drive, sample mid-cycle, compare, update model, advance
    task automatic cycle(input logic rdy);
        logic [VC:0] exp_sel;
        bit          exp_valid;
        out_ready = rdy;
        drive_inputs();
        #3;
        exp_sel   = m_locked ? (VC+1)'(1 << m_vc) : (VC+1)'(1 << VC);
        exp_valid = m_locked && (cnt[m_vc] > 0);
        check("vc_plane_sel", 32'(vc_plane_sel), 32'(exp_sel));
        check("cur_vc", 32'(cur_vc), m_locked ? 32'(m_vc) : 32'd0);
        check("out_valid", 32'(out_valid), 32'(exp_valid));
        check("pop", 32'(pop), 32'(exp_valid && rdy));
        check("pkt_done", 32'(pkt_done), 32'(m_done));
        check("stall_release", 32'(stall_release), 32'(m_srel));
        if (pop === 1'b1) n_pop++;
        if (pkt_done === 1'b1) n_done++;
        if (stall_release === 1'b1) n_srel++;
        if (prev_none && vc_plane_sel[VC] === 1'b0 && g_n < 32) begin
            for (int v = 0; v < VC; v++) if (vc_plane_sel[v] === 1'b1) g_log[g_n] = v;
            g_n++;
        end
        prev_none = (vc_plane_sel[VC] === 1'b1);
        model_step(rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(rdy);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sel"}, 32'(vc_plane_sel), 32'h10);
        check({tag, "_cur_vc"}, 32'(cur_vc), 32'd0);
        check({tag, "_pop"}, 32'(pop), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    // Full reset with empty FIFOs
    task automatic do_reset();
        rst = 1'b1;
        fifo_clear();
        out_ready = 1'b1;
        drive_inputs();
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        check("reset_pkt_done", 32'(pkt_done), 32'd0);
        check("reset_stall_release", 32'(stall_release), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        clr_stats();
    endtask

    // Next flit of a per-plane random packet generator
    task automatic gen_flit(input int v);
        int len;
        if (gen_rem[v] == 0) begin
            len = $urandom_range(1, 4);
            if (len == 1) fifo_push(v, c_FLIT_HEADTAIL);
            else begin
                fifo_push(v, c_FLIT_HEAD);
                gen_rem[v] = len - 1;
            end
        end else begin
            fifo_push(v, (gen_rem[v] == 1) ? c_FLIT_TAIL : c_FLIT_BODY);
            gen_rem[v]--;
        end
    endtask

    task automatic random_phase(input int n, input int push_div);
        for (int i = 0; i < n; i++) begin
            for (int v = 0; v < VC; v++) begin
                if ($urandom_range(0, push_div - 1) == 0) gen_flit(v);
            end
            cycle($urandom_range(0, 3) != 0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        vc_empty  = '1;
        flit_type = 2'b00;
        out_ready = 1'b0;
        fifo_clear();
        model_reset();
        clr_stats();

        // 1: reset, all planes empty, nothing selected or popped
        do_reset();
        run(10, 1'b1);
        check("idle_no_pop", 32'(n_pop), 32'd0);

        // 2: three-flit packet on plane 2
        clr_stats();
        fifo_push(2, c_FLIT_HEAD);
        fifo_push(2, c_FLIT_BODY);
        fifo_push(2, c_FLIT_TAIL);
        run(8, 1'b1);
        check("pkt2_pops", 32'(n_pop), 32'd3);
        check("pkt2_done", 32'(n_done), 32'd1);
        check("pkt2_grant", 32'(g_log[0]), 32'd2);

        // 3: single-flit packets on 0,1,3 are served in round-robin order
        do_reset();
        fifo_push(0, c_FLIT_HEADTAIL);
        fifo_push(1, c_FLIT_HEADTAIL);
        fifo_push(3, c_FLIT_HEADTAIL);
        run(10, 1'b1);
        check("rr_count", 32'(g_n), 32'd3);
        check("rr_first", 32'(g_log[0]), 32'd0);
        check("rr_second", 32'(g_log[1]), 32'd1);
        check("rr_third", 32'(g_log[2]), 32'd3);
        check("rr_pops", 32'(n_pop), 32'd3);

        // 4: plane 1 stalls mid-packet; plane 0 waits for the forced release
        clr_stats();
        fifo_push(1, c_FLIT_HEAD);
        run(2, 1'b1);
        fifo_push(0, c_FLIT_HEADTAIL);
        run(25, 1'b1);
        check("stall_pulses", 32'(n_srel), 32'd1);
        check("stall_first", 32'(g_log[0]), 32'd1);
        check("stall_next", 32'(g_log[1]), 32'd0);
        fifo_push(1, c_FLIT_BODY);
        fifo_push(1, c_FLIT_TAIL);
        run(8, 1'b1);

        // 5: back-pressure with flits present holds the lock without stalling
        clr_stats();
        fifo_push(3, c_FLIT_HEAD);
        fifo_push(3, c_FLIT_BODY);
        fifo_push(3, c_FLIT_BODY);
        fifo_push(3, c_FLIT_TAIL);
        run(2, 1'b1);
        run(40, 1'b0);
        check("hold_pops", 32'(n_pop), 32'd1);
        check("hold_srel", 32'(n_srel), 32'd0);
        run(6, 1'b1);
        check("hold_resume_pops", 32'(n_pop), 32'd4);
        check("hold_resume_done", 32'(n_done), 32'd1);

        // 6: reset mid-packet drops the lock at once; plane 0 wins afterwards
        clr_stats();
        fifo_push(2, c_FLIT_HEAD);
        fifo_push(2, c_FLIT_BODY);
        fifo_push(2, c_FLIT_TAIL);
        run(2, 1'b1);
        fifo_push(0, c_FLIT_HEADTAIL);
        out_ready = 1'b1;
        drive_inputs();
        rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        clr_stats();
        run(10, 1'b1);
        check("post_reset_first", 32'(g_log[0]), 32'd0);
        check("post_reset_second", 32'(g_log[1]), 32'd2);

        // Randomized traffic: dense, then sparse enough to provoke stalls
        do_reset();
        random_phase(1500, 3);
        random_phase(1500, 10);
        random_phase(500, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_vc_plane_scheduler
`default_nettype wire
